// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the IF/EX SRAM port arbiter.
package sram_port_arbiter_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned STRB_W          = DATA_W / 8;
    localparam int unsigned OUTSTANDING_DEF = 4;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Pipeline-side and memory-side SRAM-like handshake signals of the arbiter.
interface sram_port_arbiter_if;
    import sram_port_arbiter_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [STRB_W-1:0] data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [STRB_W-1:0] mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/sram_owner_fifo.sv
// In-order FIFO of 1-bit request owners; head names who gets the next response.
module sram_owner_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             push_owner,
    input  logic             pop,
    output logic             head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_owner;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// 2:1 arbiter sharing one SRAM-like port between instruction fetch and data access.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = OUTSTANDING_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    sram_port_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

    arb_state_e       state_q, state_d;
    logic             lock_owner_q, lock_owner_d;
    logic             run_q;
    logic             sel_owner;
    logic             sel_req;
    mem_cmd_t         inst_cmd, data_cmd, sel_cmd;
    logic             mem_req_c;
    logic             accept_c;
    logic             pop_c;
    logic             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign inst_cmd = '{wr: 1'b0, size: SIZE_WORD, wstrb: '0, addr: bus.inst_addr, wdata: '0};
    assign data_cmd = '{wr: bus.data_wr, size: bus.data_size, wstrb: bus.data_wstrb,
                        addr: bus.data_addr, wdata: bus.data_wdata};

    // A stalled request keeps the port until accepted; otherwise data wins.
    always_comb begin
        sel_owner = OWNER_INST;
        if (state_q == ARB_LOCKED) begin
            sel_owner = lock_owner_q;
        end else if (bus.data_req) begin
            sel_owner = OWNER_DATA;
        end
    end

    assign sel_req   = (sel_owner == OWNER_DATA) ? bus.data_req : bus.inst_req;
    assign sel_cmd   = (sel_owner == OWNER_DATA) ? data_cmd : inst_cmd;
    assign mem_req_c = run_q & sel_req & ~fifo_full;
    assign accept_c  = mem_req_c & bus.mem_addr_ok;
    assign pop_c     = run_q & bus.mem_data_ok;

    assign bus.mem_req   = mem_req_c;
    assign bus.mem_wr    = run_q & sel_cmd.wr;
    assign bus.mem_size  = sel_cmd.size;
    assign bus.mem_wstrb = run_q ? sel_cmd.wstrb : '0;
    assign bus.mem_addr  = sel_cmd.addr;
    assign bus.mem_wdata = sel_cmd.wdata;

    assign bus.inst_addr_ok = accept_c & (sel_owner == OWNER_INST);
    assign bus.data_addr_ok = accept_c & (sel_owner == OWNER_DATA);

    // A response with nothing outstanding is dropped.
    assign bus.inst_data_ok = pop_c & ~fifo_empty & (fifo_head == OWNER_INST);
    assign bus.data_data_ok = pop_c & ~fifo_empty & (fifo_head == OWNER_DATA);
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;

    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (mem_req_c && !bus.mem_addr_ok) begin
                    state_d      = ARB_LOCKED;
                    lock_owner_d = sel_owner;
                end
            end
            ARB_LOCKED: begin
                if (accept_c) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // run_q holds every output quiet through reset and the release cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ARB_IDLE;
            lock_owner_q <= OWNER_INST;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            run_q        <= 1'b1;
        end
    end

    sram_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (resetn),
        .push       (accept_c),
        .push_owner (sel_owner),
        .pop        (pop_c),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: priority, lock, routing, full stall and reset.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    sram_port_arbiter_if bus();

    sram_port_arbiter #(.OUTSTANDING(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = '0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_size   = SIZE_WORD;
        bus.data_wstrb  = '0;
        bus.data_addr   = '0;
        bus.data_wdata  = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        resetn = 1'b0;

        // Reset with requests pending: everything quiet.
        bus.inst_req    = 1'b1;
        bus.data_req    = 1'b1;
        bus.data_wr     = 1'b1;
        bus.data_wstrb  = 4'hF;
        bus.mem_addr_ok = 1'b1;
        #12;
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_data_addr_ok", 32'(bus.data_addr_ok), 32'd0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        idle_inputs();
        #3;
        resetn = 1'b1;
        #1;
        check("release_mem_req", 32'(bus.mem_req), 32'd0);
        cyc();
        check("rst_count", 32'(dut.fifo_count), 32'd0);

        // Arbitration: data first, then inst.
        bus.inst_req    = 1'b1;
        bus.inst_addr   = 32'h0000_0100;
        bus.data_req    = 1'b1;
        bus.data_addr   = 32'h0000_0200;
        bus.mem_addr_ok = 1'b1;
        #1;
        check("arb0_data_addr_ok", 32'(bus.data_addr_ok), 32'd1);
        check("arb0_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
        check("arb0_mem_addr", bus.mem_addr, 32'h0000_0200);
        cyc();
        bus.data_req = 1'b0;
        #1;
        check("arb1_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
        check("arb1_mem_addr", bus.mem_addr, 32'h0000_0100);
        check("arb1_mem_size", 32'(bus.mem_size), 32'(SIZE_WORD));
        cyc();
        bus.inst_req    = 1'b0;
        bus.mem_addr_ok = 1'b0;
        #1;
        check("arb_count", 32'(dut.fifo_count), 32'd2);

        // Responses route in acceptance order.
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h1111_1111;
        #1;
        check("rsp0_data_ok", 32'(bus.data_data_ok), 32'd1);
        check("rsp0_inst_ok", 32'(bus.inst_data_ok), 32'd0);
        check("rsp0_rdata", bus.data_rdata, 32'h1111_1111);
        cyc();
        bus.mem_rdata = 32'h2222_2222;
        #1;
        check("rsp1_inst_ok", 32'(bus.inst_data_ok), 32'd1);
        check("rsp1_data_ok", 32'(bus.data_data_ok), 32'd0);
        check("rsp1_rdata", bus.inst_rdata, 32'h2222_2222);
        cyc();
        bus.mem_data_ok = 1'b0;
        #1;
        check("rsp_count", 32'(dut.fifo_count), 32'd0);

        // Lock: stalled fetch is not preempted by a later store.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0300;
        #1;
        check("lock0_mem_req", 32'(bus.mem_req), 32'd1);
        check("lock0_mem_addr", bus.mem_addr, 32'h0000_0300);
        cyc();
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_wstrb = 4'hF;
        bus.data_addr  = 32'h0000_0400;
        bus.data_wdata = 32'hDEAD_BEEF;
        #1;
        check("lock1_mem_addr", bus.mem_addr, 32'h0000_0300);
        check("lock1_mem_wr", 32'(bus.mem_wr), 32'd0);
        cyc();
        #1;
        check("lock2_mem_addr", bus.mem_addr, 32'h0000_0300);
        cyc();
        bus.mem_addr_ok = 1'b1;
        #1;
        check("lock3_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
        check("lock3_data_addr_ok", 32'(bus.data_addr_ok), 32'd0);
        cyc();
        bus.inst_req = 1'b0;
        #1;
        check("lock4_data_addr_ok", 32'(bus.data_addr_ok), 32'd1);
        check("lock4_mem_wr", 32'(bus.mem_wr), 32'd1);
        check("lock4_mem_wstrb", 32'(bus.mem_wstrb), 32'hF);
        check("lock4_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        cyc();
        idle_inputs();
        bus.mem_data_ok = 1'b1;
        #1;
        check("lock_rsp0_inst_ok", 32'(bus.inst_data_ok), 32'd1);
        cyc();
        #1;
        check("lock_rsp1_store_ok", 32'(bus.data_data_ok), 32'd1);
        cyc();
        bus.mem_data_ok = 1'b0;

        // Full stall: four loads accepted, fifth waits for a pop.
        bus.data_req    = 1'b1;
        bus.data_addr   = 32'h0000_0500;
        bus.mem_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fill_addr_ok", 32'(bus.data_addr_ok), 32'd1);
            cyc();
        end
        #1;
        check("full_count", 32'(dut.fifo_count), 32'd4);
        check("full_mem_req", 32'(bus.mem_req), 32'd0);
        check("full_addr_ok", 32'(bus.data_addr_ok), 32'd0);
        bus.mem_data_ok = 1'b1;
        #1;
        check("full_pop_data_ok", 32'(bus.data_data_ok), 32'd1);
        check("full_pop_mem_req", 32'(bus.mem_req), 32'd0);
        cyc();
        bus.mem_data_ok = 1'b0;
        #1;
        check("after_pop_mem_req", 32'(bus.mem_req), 32'd1);
        check("after_pop_addr_ok", 32'(bus.data_addr_ok), 32'd1);
        cyc();
        bus.data_req    = 1'b0;
        bus.mem_addr_ok = 1'b0;
        #1;
        check("refill_count", 32'(dut.fifo_count), 32'd4);

        // Drain to two, then push and pop together.
        bus.mem_data_ok = 1'b1;
        cyc();
        cyc();
        bus.mem_data_ok = 1'b0;
        #1;
        check("drain_count", 32'(dut.fifo_count), 32'd2);
        bus.inst_req    = 1'b1;
        bus.inst_addr   = 32'h0000_0600;
        bus.mem_addr_ok = 1'b1;
        bus.mem_data_ok = 1'b1;
        #1;
        check("pp_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
        check("pp_data_ok_old_head", 32'(bus.data_data_ok), 32'd1);
        cyc();
        bus.inst_req    = 1'b0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        #1;
        check("pp_count", 32'(dut.fifo_count), 32'd2);
        bus.mem_data_ok = 1'b1;
        #1;
        check("pp_head_data", 32'(bus.data_data_ok), 32'd1);
        cyc();
        #1;
        check("pp_head_inst", 32'(bus.inst_data_ok), 32'd1);
        cyc();
        bus.mem_data_ok = 1'b0;
        #1;
        check("pp_drained", 32'(dut.fifo_count), 32'd0);

        // Asynchronous reset with three outstanding.
        bus.data_req    = 1'b1;
        bus.mem_addr_ok = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.data_req = 1'b0;
        #1;
        check("pre_rst_count", 32'(dut.fifo_count), 32'd3);
        bus.inst_req    = 1'b1;
        bus.mem_data_ok = 1'b1;
        #1;
        check("pre_rst_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
        check("mid_rst_data_ok", 32'(bus.data_data_ok), 32'd0);
        check("mid_rst_count", 32'(dut.fifo_count), 32'd0);
        cyc();
        bus.inst_req    = 1'b0;
        bus.mem_addr_ok = 1'b0;
        resetn          = 1'b1;
        cyc();
        check("post_rst_count", 32'(dut.fifo_count), 32'd0);
        check("post_rst_data_ok", 32'(bus.data_data_ok), 32'd0);
        check("post_rst_inst_ok", 32'(bus.inst_data_ok), 32'd0);
        cyc();
        check("post_rst_count2", 32'(dut.fifo_count), 32'd0);
        bus.mem_data_ok = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
